// File: rtl/cell_locator.sv
// cell_locator: raster-scan Sudoku board tracker.
// Follows the beam pixel by pixel and reports, one cycle later, whether it is
// inside a cell (with row/col and in-cell offset), on a thin/thick grid line,
// or off the board. Each axis has its own tracker driven by counters and
// boundary comparators. A sticky seq_err flags skipped pixels or lines.
// Optional feature: define CELL_LOCATOR_CURSOR_EN to add the cursor_row/
// cursor_col inputs and the cursor_hit output.
module cell_locator #(
   parameter int unsigned COORD_W   = 10,
   parameter int unsigned GRID_N    = 9,
   parameter int unsigned BOX_N     = 3,
   parameter int unsigned ORIGIN_X  = 103,
   parameter int unsigned ORIGIN_Y  = 23,
   parameter int unsigned CELL_SIZE = 48,
   parameter int unsigned THIN_W    = 1,
   parameter int unsigned THICK_W   = 2,
   parameter int unsigned IDX_W     = 4,
   parameter int unsigned REL_W     = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               beam_valid,
   input  logic [COORD_W-1:0] beam_line,
   input  logic [COORD_W-1:0] beam_pixel,
   output logic               cell_hit,
   output logic [IDX_W-1:0]   cell_row,
   output logic [IDX_W-1:0]   cell_col,
   output logic [REL_W-1:0]   rel_line,
   output logic [REL_W-1:0]   rel_pixel,
   output logic               grid_line,
   output logic               thick_line,
   output logic               out_valid,
   output logic               seq_err
`ifdef CELL_LOCATOR_CURSOR_EN
  ,input  logic [IDX_W-1:0]   cursor_row
  ,input  logic [IDX_W-1:0]   cursor_col
  ,output logic               cursor_hit
`endif
);

   localparam logic [1:0] RGN_PRE  = 2'd0;
   localparam logic [1:0] RGN_CELL = 2'd1;
   localparam logic [1:0] RGN_GAP  = 2'd2;
   localparam logic [1:0] RGN_POST = 2'd3;

   // Boundary registers are wide enough to hold any cell start of the
   // configured grid plus one spare bit, so a grid wider than the screen
   // never wraps onto a small coordinate.
   localparam int unsigned ORG_MAX = (ORIGIN_X > ORIGIN_Y) ? ORIGIN_X : ORIGIN_Y;
   localparam int unsigned SPAN    = ORG_MAX + GRID_N * (CELL_SIZE + THICK_W + THIN_W) + 1;
   localparam int unsigned SPAN_W  = $clog2(SPAN + 1);
   localparam int unsigned BND_W   = ((SPAN_W > COORD_W) ? SPAN_W : COORD_W) + 1;
   localparam int unsigned BOX_W   = (BOX_N > 1) ? $clog2(BOX_N) : 1;

   localparam logic [BND_W-1:0] ORG_X_B    = BND_W'(ORIGIN_X);
   localparam logic [BND_W-1:0] ORG_Y_B    = BND_W'(ORIGIN_Y);
   localparam logic [BND_W-1:0] STEP_THIN  = BND_W'(CELL_SIZE + THIN_W);
   localparam logic [BND_W-1:0] STEP_THICK = BND_W'(CELL_SIZE + THICK_W);
   localparam logic [REL_W-1:0] OFF_LAST   = REL_W'(CELL_SIZE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(GRID_N - 1);
   localparam logic [BOX_W-1:0] BOX_LAST   = BOX_W'(BOX_N - 1);

   // One axis tracker. bnd holds the start of the next cell to enter;
   // thick marks that the gap following the current cell is a box separator.
   typedef struct packed {
      logic [1:0]       rgn;
      logic [IDX_W-1:0] idx;
      logic [BOX_W-1:0] box;
      logic [REL_W-1:0] off;
      logic [BND_W-1:0] bnd;
      logic             thick;
   } trk_t;

   localparam trk_t TRK_X_RST = '{rgn: RGN_PRE, idx: '0, box: '0, off: '0, bnd: ORG_X_B, thick: 1'b0};
   localparam trk_t TRK_Y_RST = '{rgn: RGN_PRE, idx: '0, box: '0, off: '0, bnd: ORG_Y_B, thick: 1'b0};

   function automatic trk_t enter_cell(trk_t t, logic [BND_W-1:0] c);
      trk_t n;
      n       = t;
      n.rgn   = RGN_CELL;
      n.off   = '0;
      n.thick = (t.box == BOX_LAST);
      n.bnd   = c + (n.thick ? STEP_THICK : STEP_THIN);
      return n;
   endfunction

   function automatic trk_t next_cell(trk_t t, logic [BND_W-1:0] c);
      trk_t n;
      n     = t;
      n.idx = t.idx + IDX_W'(1);
      n.box = (t.box == BOX_LAST) ? '0 : t.box + BOX_W'(1);
      return enter_cell(n, c);
   endfunction

   // Re-arm is applied first so that a coordinate landing on the origin in
   // the re-arm cycle is evaluated against the fresh boundary immediately.
   function automatic trk_t trk_step(trk_t t, logic rearm, logic [BND_W-1:0] c,
                                     logic [BND_W-1:0] origin);
      trk_t n;
      n = t;
      if (rearm) begin
         n.rgn   = RGN_PRE;
         n.idx   = '0;
         n.box   = '0;
         n.off   = '0;
         n.bnd   = origin;
         n.thick = 1'b0;
      end
      case (n.rgn)
         RGN_PRE: begin
            if (c == n.bnd) n = enter_cell(n, c);
         end
         RGN_CELL: begin
            if (n.off == OFF_LAST) begin
               if (n.idx == IDX_LAST)  n.rgn = RGN_POST;
               else if (c == n.bnd)    n = next_cell(n, c);
               else                    n.rgn = RGN_GAP;
            end else begin
               n.off = n.off + REL_W'(1);
            end
         end
         RGN_GAP: begin
            if (c == n.bnd) n = next_cell(n, c);
         end
         default: ;
      endcase
      return n;
   endfunction

   trk_t               x_q, x_d;
   trk_t               y_q, y_d;
   logic [COORD_W-1:0] prev_pix_q, prev_pix_d;
   logic [COORD_W-1:0] prev_line_q, prev_line_d;
   logic               first_q, first_d;
   logic               seq_err_q, seq_err_d;
   logic               out_valid_q, out_valid_d;
   logic               pix_zero, line_zero, seq_hit;

   // Tracker and sequence-check next state; everything holds while beam_valid is low.
   always_comb begin
      pix_zero    = (beam_pixel == '0);
      line_zero   = (beam_line == '0);
      x_d         = x_q;
      y_d         = y_q;
      prev_pix_d  = prev_pix_q;
      prev_line_d = prev_line_q;
      first_d     = first_q;
      seq_hit     = 1'b0;
      out_valid_d = beam_valid;
      if (beam_valid) begin
         x_d = trk_step(x_q, pix_zero, BND_W'(beam_pixel), ORG_X_B);
         if (pix_zero) y_d = trk_step(y_q, line_zero, BND_W'(beam_line), ORG_Y_B);
         if (!first_q) begin
            if (pix_zero) seq_hit = !line_zero && (beam_line != prev_line_q + COORD_W'(1));
            else          seq_hit = (beam_pixel != prev_pix_q + COORD_W'(1));
         end
         prev_pix_d  = beam_pixel;
         prev_line_d = beam_line;
         first_d     = 1'b0;
      end
      seq_err_d = seq_err_q | seq_hit;
   end

   // State registers; reset leaves both trackers off-board in PRE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q         <= TRK_X_RST;
         y_q         <= TRK_Y_RST;
         prev_pix_q  <= '0;
         prev_line_q <= '0;
         first_q     <= 1'b1;
         seq_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         prev_pix_q  <= prev_pix_d;
         prev_line_q <= prev_line_d;
         first_q     <= first_d;
         seq_err_q   <= seq_err_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Classification straight from the registered trackers gives the 1-cycle latency.
   always_comb begin
      logic x_cell, y_cell, x_gap, y_gap, x_on, y_on;
      x_cell     = (x_q.rgn == RGN_CELL);
      y_cell     = (y_q.rgn == RGN_CELL);
      x_gap      = (x_q.rgn == RGN_GAP);
      y_gap      = (y_q.rgn == RGN_GAP);
      x_on       = x_cell || x_gap;
      y_on       = y_cell || y_gap;
      cell_hit   = x_cell && y_cell;
      grid_line  = x_on && y_on && (x_gap || y_gap);
      thick_line = grid_line && ((x_gap && x_q.thick) || (y_gap && y_q.thick));
      cell_row   = cell_hit ? y_q.idx : '0;
      cell_col   = cell_hit ? x_q.idx : '0;
      rel_line   = cell_hit ? y_q.off : '0;
      rel_pixel  = cell_hit ? x_q.off : '0;
   end

   assign out_valid = out_valid_q;
   assign seq_err   = seq_err_q;

`ifdef CELL_LOCATOR_CURSOR_EN
   logic [IDX_W-1:0] cur_row_q, cur_col_q;

   // Cursor position is captured with the beam so the compare lines up with the hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_row_q <= '0;
         cur_col_q <= '0;
      end else if (beam_valid) begin
         cur_row_q <= cursor_row;
         cur_col_q <= cursor_col;
      end
   end

   assign cursor_hit = cell_hit && (y_q.idx == cur_row_q) && (x_q.idx == cur_col_q);
`endif

endmodule

// File: doc/cell_locator.md
# cell_locator

Raster-scan cell tracker for the Sudoku board renderer. It follows the VGA beam position pixel by pixel and reports, one cycle later, whether the beam is inside a board cell, on a thin or thick grid line, or off the board. For in-cell pixels it also reports the cell's row/column and the beam offset within the cell. The grid is parametrised: N×N cells, B×B boxes, configurable origin, cell size and line widths. Boundaries are tracked with counters and comparators, with no per-row/column lookup table and no dividers, and the block sits between the VGA timing generator and the glyph/colour mux.

## Interface
- COORD_W, 10, width of line/pixel coordinates
- GRID_N, 9, cells per side
- BOX_N, 3, cells per box side; GRID_N must be a multiple of it
- ORIGIN_X, 103, first pixel of column 0
- ORIGIN_Y, 23, first line of row 0
- CELL_SIZE, 48, cell width and height in pixels
- THIN_W, 1, width of a grid line inside a box
- THICK_W, 2, width of a grid line between boxes
- IDX_W, 4, width of the row/col index outputs
- REL_W, 6, width of the in-cell offset outputs
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- beam_valid  in  1  beam_line/beam_pixel describe a displayed pixel this cycle
- beam_line  in  COORD_W  current scan line
- beam_pixel  in  COORD_W  current pixel within the line
- cell_hit  out  1  beam is inside a cell
- cell_row  out  IDX_W  row of the hit cell
- cell_col  out  IDX_W  column of the hit cell
- rel_line  out  REL_W  line offset within the cell, 0..CELL_SIZE-1
- rel_pixel  out  REL_W  pixel offset within the cell, 0..CELL_SIZE-1
- grid_line  out  1  beam is on an interior grid line
- thick_line  out  1  qualifies grid_line: the line is a box separator
- out_valid  out  1  registered copy of beam_valid
- seq_err  out  1  sticky error: the beam skipped a pixel or line
- cursor_row, cursor_col  in  IDX_W each  cursor cell; present only with the macro
- cursor_hit  out  1  the hit cell is the cursor cell; present only with the macro

## Operation
- Each axis has its own tracker: region (PRE, CELL, GAP, POST), cell index, offset counter, and next-boundary register.
- Cell k spans [start_k, start_k+CELL_SIZE-1]. start_0 is the origin.
- start_{k+1} = start_k + CELL_SIZE + THICK_W when (k+1) mod BOX_N == 0, otherwise + THIN_W.
- Default grid gives column starts 103, 152, 201, 251, 300, 349, 399, 448, 497 and row starts 23, 72, 121, 171, 220, 269, 319, 368, 417.
- X tracker, on each beam_valid cycle:
  - beam_pixel == 0 re-arms it to PRE, index 0, boundary ORIGIN_X.
  - Otherwise it advances by one pixel.
  - PRE→CELL when the pixel equals the boundary.
  - CELL→GAP after CELL_SIZE pixels; index increments on GAP→CELL.
  - CELL→POST after the last cell.
- Y tracker: same transitions, advanced once per line on the beam_pixel == 0 cycle. It re-arms when beam_line == 0 && beam_pixel == 0.
- Output classification:
  - cell_hit = both axes in CELL.
  - grid_line = neither axis in PRE/POST and at least one axis in GAP.
  - thick_line = the gap being crossed (either axis) precedes a box start.
- Outputs are forced to 0 when not cell_hit:
  - cell_row, cell_col, rel_line, rel_pixel when cell_hit is 0.
  - thick_line when grid_line is 0.
- seq_err sets when either condition holds on a valid cycle:
  - beam_pixel ≠ 0 and beam_pixel ≠ prev_pixel+1.
  - beam_pixel == 0 and beam_line ∉ {0, prev_line+1}.
- seq_err clears only on reset. Trackers then resynchronise at the next re-arm point.
- beam_valid low: trackers hold, out_valid=0, all other outputs hold their last value.

## Timing
- Latency is 1 cycle: outputs reflect the beam_valid/beam_line/beam_pixel sampled on the previous rising edge.
- Async reset: all outputs 0.
- Async reset: trackers go to PRE with index 0, and prev_pixel/prev_line go to 0. The first valid pixel after reset is not flagged by seq_err.
- Reset mid-frame: outputs stay 0/off-board until the next re-arm. seq_err is not set by the resume.
- Grid wider than the screen: trackers saturate in CELL/GAP and never wrap. Index never exceeds GRID_N-1.
- Pixel 0 falling inside the grid region is a legal configuration. The trackers then evaluate against the boundary on that same cycle.

## Configuration
- CELL_LOCATOR_CURSOR_EN defined:
  - Adds cursor_row, cursor_col and cursor_hit.
  - cursor_hit = cell_hit && row/col match the cursor inputs, with the cursor sampled with the beam, so latency is 1.
  - cursor_hit resets to 0.
- Macro undefined: these ports and their logic do not exist.

## Test plan
- Default parameters, full 640×480 contiguous scan, line 23:
  - pixel 103 → cell_hit=1, col 0, rel_pixel 0.
  - pixel 150 → rel_pixel 47.
  - pixel 151 → grid_line=1, thick_line=0.
  - pixels 249–250 → thick_line=1.
  - pixel 545 → all 0.
- Line 22 and line 466 → cell_hit=0 and grid_line=0 for every pixel. Line 71 inside board columns → grid_line=1, thin.
- Line 417, pixel 497 → row 8, col 8, rel 0/0. Line 464, pixel 544 → rel 47/47.
- Pixel jump 200→205 on line 50 → seq_err=1 next cycle and stays 1. Trackers are correct again from the next line 0 / pixel 0.
- Assert rst_n low at line 300 → outputs 0 immediately. Release and resume at line 301 → no seq_err, no hits until the next frame start.
- With CELL_LOCATOR_CURSOR_EN and cursor (4,5) → cursor_hit=1 exactly for lines 220–267 × pixels 349–396, and 0 elsewhere.
